// File: rtl/led_pattern_gen.sv
// LED pattern generator: prescaled binary, gray, bounce-scan and breathe
// patterns on N_LEDS outputs, with a step tick for neighbouring logic.
module led_pattern_gen #(
    parameter int N_LEDS    = 5,
    parameter int LOG2DELAY = 22,
    parameter int PWM_BITS  = 8
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              enable,
    input  logic [1:0]        mode,
    output logic [N_LEDS-1:0] leds,
    output logic              step_tick
);

    localparam int PW = (N_LEDS > 1) ? $clog2(N_LEDS) : 1;
    localparam logic [PW-1:0] POS_MAX = PW'(N_LEDS - 1);

    logic [LOG2DELAY-1:0] presc_q, presc_d;
    logic [N_LEDS-1:0]    step_q, step_d;
    logic [PW-1:0]        pos_q, pos_d;
    logic                 dir_q, dir_d;
    logic [PWM_BITS-1:0]  duty_q, duty_d;
    logic                 duty_dn_q, duty_dn_d;
    logic [PWM_BITS-1:0]  pwm_q, pwm_d;
    logic [1:0]           mode_q, mode_d;
    logic [N_LEDS-1:0]    leds_q, leds_d;
    logic                 tick_q, tick_d;

    logic mode_chg;
    logic wrap;

    always_comb begin
        mode_chg  = (mode != mode_q);
        wrap      = enable && (presc_q == '1);
        presc_d   = presc_q;
        step_d    = step_q;
        pos_d     = pos_q;
        dir_d     = dir_q;
        duty_d    = duty_q;
        duty_dn_d = duty_dn_q;
        tick_d    = 1'b0;
        pwm_d     = pwm_q + PWM_BITS'(1);
        mode_d    = mode;

        // A mode switch restarts the sequence and swallows any same-cycle wrap
        if (mode_chg) begin
            presc_d   = '0;
            step_d    = '0;
            pos_d     = '0;
            dir_d     = 1'b0;
            duty_d    = '0;
            duty_dn_d = 1'b0;
        end else begin
            if (enable) begin
                presc_d = presc_q + LOG2DELAY'(1);
            end
            if (wrap) begin
                tick_d = 1'b1;
                step_d = step_q + N_LEDS'(1);
                if (N_LEDS > 1) begin
                    if (!dir_q) begin
                        pos_d = pos_q + PW'(1);
                        if (pos_d == POS_MAX) dir_d = 1'b1;
                    end else begin
                        pos_d = pos_q - PW'(1);
                        if (pos_d == '0) dir_d = 1'b0;
                    end
                end
                if (!duty_dn_q) begin
                    duty_d = duty_q + PWM_BITS'(1);
                    if (duty_d == '1) duty_dn_d = 1'b1;
                end else begin
                    duty_d = duty_q - PWM_BITS'(1);
                    if (duty_d == '0) duty_dn_d = 1'b0;
                end
            end
        end

        case (mode_q)
            2'd0:    leds_d = step_q;
            2'd1:    leds_d = step_q ^ (step_q >> 1);
            2'd2:    leds_d = N_LEDS'(1) << pos_q;
            default: leds_d = {N_LEDS{pwm_q < duty_q}};
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            presc_q   <= '0;
            step_q    <= '0;
            pos_q     <= '0;
            dir_q     <= 1'b0;
            duty_q    <= '0;
            duty_dn_q <= 1'b0;
            pwm_q     <= '0;
            mode_q    <= '0;
            leds_q    <= '0;
            tick_q    <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            step_q    <= step_d;
            pos_q     <= pos_d;
            dir_q     <= dir_d;
            duty_q    <= duty_d;
            duty_dn_q <= duty_dn_d;
            pwm_q     <= pwm_d;
            mode_q    <= mode_d;
            leds_q    <= leds_d;
            tick_q    <= tick_d;
        end
    end

    assign leds      = leds_q;
    assign step_tick = tick_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen with a queue of expected LED values
// popped one cycle after each observed step tick.
module tb_led_pattern_gen;

    logic       clk;
    logic       resetn;
    logic       enable;
    logic [1:0] mode;
    logic [4:0] leds;
    logic       step_tick;

    int errors = 0;
    int checks = 0;
    int exp_q[$];

    led_pattern_gen #(
        .N_LEDS(5),
        .LOG2DELAY(2),
        .PWM_BITS(3)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .enable(enable),
        .mode(mode),
        .leds(leds),
        .step_tick(step_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pop_cmp(input string tag, input logic [31:0] obs);
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s: observed=%0h expected=<empty scoreboard>", tag, obs);
        end else begin
            chk(tag, obs, exp_q.pop_front());
        end
    endtask

    task automatic wait_tick(output int gap, input bit oneh);
        gap = 0;
        do begin
            cyc();
            gap++;
            if (oneh) chk("onehot", {31'd0, $onehot(leds)}, 1);
        end while (step_tick !== 1'b1 && gap < 64);
    endtask

    task automatic run_ticks(input int n, input int first_gap,
                             input bit gray, input bit oneh);
        int gap;
        logic [4:0] prev;
        prev = '0;
        for (int i = 0; i < n; i++) begin
            wait_tick(gap, oneh && i > 0);
            chk("tick_gap", gap, (i == 0) ? first_gap : 3);
            cyc();
            chk("tick_width", {31'd0, step_tick}, 0);
            pop_cmp("leds", {27'd0, leds});
            if (gray) chk("gray_1bit", $countones(leds ^ prev), 1);
            prev = leds;
        end
    endtask

    initial begin
        int gap;
        int p;
        bit dn;
        int hi;
        int t;
        int ch;
        logic [4:0] hold;
        logic [4:0] s;

        resetn = 1'b0;
        enable = 1'b1;
        mode   = 2'd0;
        #1;
        chk("rst_leds", {27'd0, leds}, 0);
        chk("rst_tick", {31'd0, step_tick}, 0);
        cyc();
        cyc();
        resetn = 1'b1;

        // binary count, full wrap
        for (int i = 1; i <= 32; i++) exp_q.push_back(i % 32);
        run_ticks(32, 4, 1'b0, 1'b0);

        // gray count
        for (int i = 1; i <= 32; i++) begin
            s = 5'(i % 32);
            exp_q.push_back(int'(s ^ (s >> 1)));
        end
        mode = 2'd1;
        run_ticks(32, 5, 1'b1, 1'b0);

        // bounce scan
        p = 0;
        dn = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (!dn) begin
                p++;
                if (p == 4) dn = 1'b1;
            end else begin
                p--;
                if (p == 0) dn = 1'b0;
            end
            exp_q.push_back(1 << p);
        end
        mode = 2'd2;
        run_ticks(9, 5, 1'b0, 1'b1);

        // breathe: freeze duty with enable low and count high cycles per 8
        p = 0;
        dn = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (!dn) begin
                p++;
                if (p == 7) dn = 1'b1;
            end else begin
                p--;
                if (p == 0) dn = 1'b0;
            end
            exp_q.push_back(p);
        end
        mode = 2'd3;
        for (int k = 0; k < 15; k++) begin
            wait_tick(gap, 1'b0);
            chk("breathe_gap", gap, (k == 0) ? 5 : 4);
            enable = 1'b0;
            cyc();
            hi = 0;
            for (int j = 0; j < 8; j++) begin
                cyc();
                if (leds === 5'h1f) hi++;
            end
            pop_cmp("breathe_hi", hi);
            enable = 1'b1;
        end

        // enable drop holds prescaler and pattern
        exp_q.push_back(1);
        exp_q.push_back(2);
        mode = 2'd0;
        wait_tick(gap, 1'b0);
        chk("resume_gap0", gap, 5);
        cyc();
        pop_cmp("leds_pre_hold", {27'd0, leds});
        enable = 1'b0;
        hold = leds;
        t = 0;
        ch = 0;
        for (int j = 0; j < 20; j++) begin
            cyc();
            if (step_tick) t++;
            if (leds !== hold) ch++;
        end
        chk("frozen_tick", t, 0);
        chk("frozen_leds", ch, 0);
        enable = 1'b1;
        wait_tick(gap, 1'b0);
        chk("resume_gap", gap, 3);
        cyc();
        pop_cmp("leds_resume", {27'd0, leds});

        // mode change on the wrap cycle discards the tick
        cyc();
        cyc();
        mode = 2'd2;
        cyc();
        chk("chg_no_tick", {31'd0, step_tick}, 0);
        cyc();
        chk("chg_pos0", {27'd0, leds}, 1);
        chk("chg_no_tick2", {31'd0, step_tick}, 0);
        exp_q.push_back(2);
        wait_tick(gap, 1'b0);
        chk("chg_gap", gap, 3);
        cyc();
        pop_cmp("chg_leds", {27'd0, leds});

        // asynchronous reset during a tick pulse
        wait_tick(gap, 1'b0);
        chk("pre_rst_gap", gap, 3);
        resetn = 1'b0;
        #1;
        chk("async_leds", {27'd0, leds}, 0);
        chk("async_tick", {31'd0, step_tick}, 0);
        mode = 2'd0;
        cyc();
        cyc();
        resetn = 1'b1;
        exp_q.push_back(1);
        run_ticks(1, 4, 1'b0, 1'b0);

        chk("sb_drain", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
